// File: rtl/id_ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_ctrl
//
// Hazard and forwarding controller that sits beside the ID/EX pipeline
// register. It watches the EX-side fields of that register and produces:
//   * load-use stalls: the PC and IF/ID are held and a bubble is inserted into
//     ID/EX for LU_STALL cycles,
//   * wrong-path flushes when EX resolves a taken branch or jump,
//   * EX-stage operand forwarding selects,
//   * two saturating performance counters.
// All hazard outputs are combinational, so they are valid before the same edge
// that the pipeline registers sample.
//
// Parameters
//   LU_STALL  load-use stall length in cycles, legal range 1..3
//   CNT_W     width of the saturating performance counters
//
// Ports
//   clk                        rising-edge clock
//   rst                        synchronous, active-low reset
//   hold                       global freeze request (memory not ready)
//   ID_rs, ID_rt               source registers of the instruction in ID
//   ID_use_rs, ID_use_rt       ID instruction actually reads rs / rt
//   EX_rd                      EX destination register (after RegDST mux)
//   EX_MemtoReg, EX_RegWrite   EX instruction is a load / writes a register
//   EX_rs, EX_rt               EX operand registers, used for forwarding
//   EX_redirect                taken branch/jump resolved in EX this cycle
//   MEM_rd, WB_rd              destination registers in MEM / WB
//   MEM_RegWrite, WB_RegWrite  write enables in MEM / WB
//   pc_stall, IF_ID_stall      hold the PC / hold the IF/ID register
//   IF_ID_flush, ID_EX_flush   load a bubble on the next edge
//   fwd_a, fwd_b               00 = register file, 01 = MEM, 10 = WB
//   stall_cycles               stalled cycles seen while not frozen by hold
//   flush_events               redirect flushes taken
// -----------------------------------------------------------------------------
module id_ex_hazard_ctrl #(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemtoReg,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_rs,
  input  logic [4:0]       EX_rt,
  input  logic             EX_redirect,
  input  logic [4:0]       MEM_rd,
  input  logic [4:0]       WB_rd,
  input  logic             MEM_RegWrite,
  input  logic             WB_RegWrite,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {
    RUN = 1'b0,
    LU  = 1'b1
  } state_t;

  // The first stall cycle is spent in RUN, so the LU down-counter starts at
  // LU_STALL-2 and the stall ends on the cycle where it reads zero.
  localparam logic [1:0] CNT_INIT = (LU_STALL > 1) ? 2'(LU_STALL - 2) : 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu_hit;
  logic       stall_inc;
  logic       flush_inc;

  assign lu_hit = EX_MemtoReg && EX_RegWrite && (EX_rd != 5'd0) &&
                  ((ID_use_rs && (ID_rs == EX_rd)) ||
                   (ID_use_rt && (ID_rt == EX_rd)));

  // Priority: reset > hold > redirect > load-use (new or in progress) > normal.
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch; blocking '=' is correct in combinational
  // logic.
  always_comb begin
    pc_stall    = 1'b0;
    IF_ID_stall = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (!rst) begin
      // Flushing during reset clears the reset-less pipeline registers.
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      state_d     = RUN;
      cnt_d       = 2'd0;
    end else if (hold) begin
      // Freeze everything; ID/EX is held by its own enable, so no bubble.
      // A pending redirect stays asserted upstream until hold drops.
      pc_stall    = 1'b1;
      IF_ID_stall = 1'b1;
    end else if (EX_redirect) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      state_d     = RUN;
      cnt_d       = 2'd0;
      flush_inc   = 1'b1;
    end else if (state_q == LU) begin
      // lu_hit is deliberately not re-evaluated while a stall is in progress.
      pc_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
      stall_inc   = 1'b1;
      if (cnt_q == 2'd0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (lu_hit) begin
      pc_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
      stall_inc   = 1'b1;
      if (LU_STALL > 1) begin
        state_d = LU;
        cnt_d   = CNT_INIT;
      end
    end
  end

  // MEM holds the younger result, so it wins over WB. Register 0 is hardwired
  // and never forwards. Selects are forced to the register file during reset.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      if (MEM_RegWrite && (MEM_rd != 5'd0) && (MEM_rd == EX_rs)) begin
        fwd_a = 2'b01;
      end else if (WB_RegWrite && (WB_rd != 5'd0) && (WB_rd == EX_rs)) begin
        fwd_a = 2'b10;
      end

      if (MEM_RegWrite && (MEM_rd != 5'd0) && (MEM_rd == EX_rt)) begin
        fwd_b = 2'b01;
      end else if (WB_RegWrite && (WB_rd != 5'd0) && (WB_rd == EX_rt)) begin
        fwd_b = 2'b10;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      cnt_q        <= 2'd0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Counters stick at all-ones instead of wrapping.
      if (stall_inc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if (flush_inc && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for id_ex_hazard_ctrl.
// Two instances share every input: instance 0 has LU_STALL = 1 and 3-bit
// counters (so saturation is reachable), instance 1 has LU_STALL = 3 and
// 16-bit counters. A reference model tracks "stall cycles still owed" per
// instance as a plain integer and recomputes every output from the rules.
// Inputs change on the falling edge; outputs are checked just after that,
// and the model advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       hold;
  logic [4:0] ID_rs, ID_rt;
  logic       ID_use_rs, ID_use_rt;
  logic [4:0] EX_rd, EX_rs, EX_rt;
  logic       EX_MemtoReg, EX_RegWrite, EX_redirect;
  logic [4:0] MEM_rd, WB_rd;
  logic       MEM_RegWrite, WB_RegWrite;

  logic [1:0] pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o;
  logic [1:0] fwd_a_0, fwd_b_0, fwd_a_1, fwd_b_1;
  logic [2:0]  sc_0, fe_0;
  logic [15:0] sc_1, fe_1;

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per instance.
  int lu_len [2] = '{1, 3};
  int cnt_max[2] = '{7, 65535};
  int rem    [2];
  int sc_m   [2];
  int fe_m   [2];
  bit cnt_known = 1'b0;

  id_ex_hazard_ctrl #(.LU_STALL(1), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .hold(hold),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .EX_rd(EX_rd), .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_redirect(EX_redirect),
    .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .pc_stall(pc_stall_o[0]), .IF_ID_stall(if_id_stall_o[0]),
    .IF_ID_flush(if_id_flush_o[0]), .ID_EX_flush(id_ex_flush_o[0]),
    .fwd_a(fwd_a_0), .fwd_b(fwd_b_0),
    .stall_cycles(sc_0), .flush_events(fe_0)
  );

  id_ex_hazard_ctrl #(.LU_STALL(3), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .hold(hold),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .EX_rd(EX_rd), .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_redirect(EX_redirect),
    .MEM_rd(MEM_rd), .WB_rd(WB_rd),
    .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .pc_stall(pc_stall_o[1]), .IF_ID_stall(if_id_stall_o[1]),
    .IF_ID_flush(if_id_flush_o[1]), .ID_EX_flush(id_ex_flush_o[1]),
    .fwd_a(fwd_a_1), .fwd_b(fwd_b_1),
    .stall_cycles(sc_1), .flush_events(fe_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit lu_hit_ref();
    if (!(EX_MemtoReg && EX_RegWrite) || EX_rd == 0) return 1'b0;
    return (ID_use_rs && ID_rs == EX_rd) || (ID_use_rt && ID_rt == EX_rd);
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] src);
    if (!rst) return 2'b00;
    if (MEM_RegWrite && MEM_rd != 0 && MEM_rd == src) return 2'b01;
    if (WB_RegWrite && WB_rd != 0 && WB_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  // Compare every output of both instances against the model.
  task automatic check_cycle();
    bit stall, bubble_if, bubble_id;
    #1;
    for (int i = 0; i < 2; i++) begin
      stall = 0; bubble_if = 0; bubble_id = 0;
      if (!rst) begin
        bubble_if = 1; bubble_id = 1;
      end else if (hold) begin
        stall = 1;
      end else if (EX_redirect) begin
        bubble_if = 1; bubble_id = 1;
      end else if (rem[i] > 0 || lu_hit_ref()) begin
        stall = 1; bubble_id = 1;
      end
      check_eq($sformatf("pc_stall[%0d]", i), 32'(pc_stall_o[i]), 32'(stall));
      check_eq($sformatf("IF_ID_stall[%0d]", i), 32'(if_id_stall_o[i]), 32'(stall));
      check_eq($sformatf("IF_ID_flush[%0d]", i), 32'(if_id_flush_o[i]), 32'(bubble_if));
      check_eq($sformatf("ID_EX_flush[%0d]", i), 32'(id_ex_flush_o[i]), 32'(bubble_id));
    end
    check_eq("fwd_a[0]", 32'(fwd_a_0), 32'(fwd_ref(EX_rs)));
    check_eq("fwd_b[0]", 32'(fwd_b_0), 32'(fwd_ref(EX_rt)));
    check_eq("fwd_a[1]", 32'(fwd_a_1), 32'(fwd_ref(EX_rs)));
    check_eq("fwd_b[1]", 32'(fwd_b_1), 32'(fwd_ref(EX_rt)));
    if (cnt_known) begin
      check_eq("stall_cycles[0]", 32'(sc_0), sc_m[0]);
      check_eq("flush_events[0]", 32'(fe_0), fe_m[0]);
      check_eq("stall_cycles[1]", 32'(sc_1), sc_m[1]);
      check_eq("flush_events[1]", 32'(fe_1), fe_m[1]);
    end
  endtask

  // Advance the model with the inputs that were present at the rising edge.
  task automatic update_model();
    bit hit;
    hit = lu_hit_ref();
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        rem[i] = 0; sc_m[i] = 0; fe_m[i] = 0;
      end else if (hold) begin
        // frozen
      end else if (EX_redirect) begin
        rem[i] = 0;
        if (fe_m[i] < cnt_max[i]) fe_m[i]++;
      end else if (rem[i] > 0 || hit) begin
        rem[i] = ((rem[i] > 0) ? rem[i] : lu_len[i]) - 1;
        if (sc_m[i] < cnt_max[i]) sc_m[i]++;
      end
    end
    if (!rst) cnt_known = 1'b1;
  endtask

  task automatic step();
    check_cycle();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1; hold = 0; EX_redirect = 0;
    ID_rs = 0; ID_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
    EX_rd = 0; EX_rs = 0; EX_rt = 0; EX_MemtoReg = 0; EX_RegWrite = 0;
    MEM_rd = 0; WB_rd = 0; MEM_RegWrite = 0; WB_RegWrite = 0;
  endtask

  // lw r5 in EX, add r6,r5,r1 in ID.
  task automatic load_use();
    EX_MemtoReg = 1; EX_RegWrite = 1; EX_rd = 5;
    ID_rs = 5; ID_rt = 1; ID_use_rs = 1; ID_use_rt = 1;
  endtask

  // Bubble in EX after the first stall edge; the ID instruction stays put.
  task automatic bubble_ex();
    EX_MemtoReg = 0; EX_RegWrite = 0; EX_rd = 0;
  endtask

  // The stalled add finally moves into EX; ID holds an unrelated instruction.
  task automatic add_in_ex();
    EX_MemtoReg = 0; EX_RegWrite = 1; EX_rd = 6;
    ID_rs = 2; ID_rt = 3;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  initial begin
    set_idle();
    @(negedge clk);

    // Reset: flushes during reset, clean state right after release.
    rst = 0;
    #1;
    check_eq("rst_IF_ID_flush", 32'(if_id_flush_o), 32'h3);
    check_eq("rst_ID_EX_flush", 32'(id_ex_flush_o), 32'h3);
    @(negedge clk);
    step();
    rst = 1;
    #1;
    check_eq("post_rst_pc_stall", 32'(pc_stall_o), 32'h0);
    check_eq("post_rst_fwd_a", 32'(fwd_a_1), 32'h0);
    check_eq("post_rst_stall_cycles", 32'(sc_1), 32'h0);
    check_eq("post_rst_flush_events", 32'(fe_1), 32'h0);
    @(negedge clk);

    // Load-use: instance 0 stalls 1 cycle, instance 1 stalls 3 cycles.
    do_reset();
    load_use();
    step();
    bubble_ex();
    #1 check_eq("lu_cycle2_pc_stall", 32'(pc_stall_o), 32'h2);
    step();
    #1 check_eq("lu_cycle3_pc_stall", 32'(pc_stall_o), 32'h2);
    step();
    add_in_ex();
    #1 check_eq("lu_cycle4_pc_stall", 32'(pc_stall_o), 32'h0);
    step();
    check_eq("lu_stall_cycles[0]", 32'(sc_0), 32'd1);
    check_eq("lu_stall_cycles[1]", 32'(sc_1), 32'd3);

    // Load into r0 never stalls.
    do_reset();
    load_use();
    EX_rd = 0; ID_rs = 0;
    #1 check_eq("r0_no_stall", 32'(pc_stall_o), 32'h0);
    step();
    set_idle();
    step();
    check_eq("r0_stall_cycles[1]", 32'(sc_1), 32'd0);

    // Redirect in the second stall cycle aborts the stall.
    do_reset();
    load_use();
    step();
    bubble_ex();
    EX_redirect = 1;
    #1;
    check_eq("redir_flushes", 32'({if_id_flush_o, id_ex_flush_o}), 32'hF);
    check_eq("redir_pc_stall", 32'(pc_stall_o), 32'h0);
    step();
    set_idle();
    #1 check_eq("after_redir_pc_stall", 32'(pc_stall_o), 32'h0);
    step();
    check_eq("redir_flush_events[1]", 32'(fe_1), 32'd1);
    check_eq("redir_stall_cycles[1]", 32'(sc_1), 32'd1);

    // Hold for 4 cycles mid-stall, then the stall finishes its 2 remaining cycles.
    do_reset();
    load_use();
    step();
    bubble_ex();
    hold = 1;
    EX_redirect = 1;  // must be ignored while frozen
    for (int i = 0; i < 4; i++) step();
    check_eq("hold_stall_cycles[1]", 32'(sc_1), 32'd1);
    check_eq("hold_flush_events[1]", 32'(fe_1), 32'd0);
    hold = 0;
    EX_redirect = 0;
    step();
    step();
    add_in_ex();
    #1 check_eq("hold_done_pc_stall", 32'(pc_stall_o), 32'h0);
    step();
    check_eq("hold_stall_cycles_end[1]", 32'(sc_1), 32'd3);
    check_eq("hold_stall_cycles_end[0]", 32'(sc_0), 32'd1);

    // Forwarding priority and register 0.
    set_idle();
    EX_rs = 7; EX_rt = 9; MEM_rd = 7; WB_rd = 7;
    MEM_RegWrite = 1; WB_RegWrite = 1;
    #1 check_eq("fwd_mem", 32'(fwd_a_1), 32'h1);
    step();
    MEM_RegWrite = 0;
    #1 check_eq("fwd_wb", 32'(fwd_a_1), 32'h2);
    step();
    MEM_RegWrite = 1; WB_rd = 9;
    #1 check_eq("fwd_b_wb", 32'(fwd_b_0), 32'h2);
    step();
    EX_rs = 0; MEM_rd = 0; WB_rd = 0;
    #1 check_eq("fwd_r0", 32'(fwd_a_1), 32'h0);
    step();

    // Saturation of the 3-bit counters.
    do_reset();
    load_use();
    for (int i = 0; i < 10; i++) step();
    set_idle();
    step();
    check_eq("sat_stall_cycles[0]", 32'(sc_0), 32'd7);
    EX_redirect = 1;
    for (int i = 0; i < 10; i++) step();
    EX_redirect = 0;
    step();
    check_eq("sat_flush_events[0]", 32'(fe_0), 32'd7);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 59) != 0);
      hold         = ($urandom_range(0, 7) == 0);
      EX_redirect  = ($urandom_range(0, 9) == 0);
      ID_rs        = 5'($urandom_range(0, 3));
      ID_rt        = 5'($urandom_range(0, 3));
      ID_use_rs    = 1'($urandom);
      ID_use_rt    = 1'($urandom);
      EX_rd        = 5'($urandom_range(0, 3));
      EX_rs        = 5'($urandom_range(0, 3));
      EX_rt        = 5'($urandom_range(0, 3));
      EX_MemtoReg  = ($urandom_range(0, 2) != 0);
      EX_RegWrite  = ($urandom_range(0, 3) != 0);
      MEM_rd       = 5'($urandom_range(0, 3));
      WB_rd        = 5'($urandom_range(0, 3));
      MEM_RegWrite = 1'($urandom);
      WB_RegWrite  = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
